systolic_pe: RTL and testbench
==============================

// Module: systolic_pe
// PURPOSE
//  Parametrised systolic-array processing element; successor to the fixed 32-bit PE. Sits in a 2-D grid:
//  activations flow west->east, partial sums (or streamed weights) flow north->south, 1-cycle hop per PE.
//  Supports weight-stationary (WS) and output-stationary (OS) dataflow with a double-buffered weight
//  shift-chain so the next tile's weights load while the current tile computes.
// PARAMETERS
//  DATA_W    8   activation width, signed
//  WEIGHT_W  8   weight width, signed
//  ACC_W     32  accumulator / partial-sum width, signed; must be >= DATA_W+WEIGHT_W (elaboration $error)
// PORTS
//  clk          in   1         single clock, all state on posedge
//  reset        in   1         synchronous, active-high; clears all state
//  mode         in   1         0 = WS, 1 = OS; sampled every cycle
//  in_valid     in   1         in_act / in_psum qualifier
//  in_act       in   DATA_W    activation from west
//  in_psum      in   ACC_W     WS: partial sum from north; OS: streamed weight in [WEIGHT_W-1:0]
//  out_valid    out  1         registered in_valid, to east/south neighbours
//  out_act      out  DATA_W    registered activation to east
//  out_psum     out  ACC_W     WS: new partial sum; OS: forwarded weight (sign-extended)
//  w_shift_en   in   1         shift weight chain one position this cycle
//  w_shift_in   in   WEIGHT_W  shadow weight from north neighbour / column head
//  w_shift_out  out  WEIGHT_W  current shadow weight, to south neighbour
//  w_swap       in   1         copy shadow weight into active weight
//  acc_clear    in   1         OS: restart accumulation
//  acc_out      out  ACC_W     OS accumulator value (registered)
// BEHAVIOUR
//  - Reset: every output and internal register (active_w, shadow_w, acc) = 0 in the cycle after reset high.
//    Reset mid-tile discards all state; no partial result retained.
//  - Latency 1 for all datapath outputs. in_valid=1: out_valid<=1, out_act<=in_act. in_valid=0: out_valid<=0,
//    out_act/out_psum hold previous values (no bubble zeroing).
//  - Product p = in_act * W (signed, DATA_W+WEIGHT_W bits), sign-extended to ACC_W.
//  - WS, in_valid: W = active_w; out_psum <= in_psum + p. acc untouched.
//  - OS, in_valid: W = in_psum[WEIGHT_W-1:0]; acc <= acc + p; out_psum <= sext(in_psum[WEIGHT_W-1:0]).
//  - acc_clear (any mode): acc <= 0; with OS in_valid same cycle acc <= p (clear wins over old acc, not over p).
//  - Weight chain: w_shift_en -> shadow_w <= w_shift_in; w_shift_out is shadow_w (register, 1-cycle per hop).
//    N-deep column fully loaded after N shift cycles.
//  - w_swap: active_w <= shadow_w (pre-shift value). Swap+shift same cycle: active gets OLD shadow,
//    shadow gets w_shift_in. Swap takes effect for in_valid beats from the next cycle.
//  - mode switch: no state cleared; acc keeps value; controller must acc_clear before new OS tile.
//  - Overflow: default wraps modulo 2^ACC_W (two's complement).
// CONFIGURATION
//  PE_SATURATE_EN defined: WS out_psum and OS acc adds saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
//  overflow detected from operand/result sign bits. Undefined: plain wrapping add, no extra logic.
// STRUCTURE
//  Package tpu_pkg: typedef enum logic {MODE_WS=1'b0, MODE_OS=1'b1} pe_mode_e; default width localparams;
//  sat_add function (used only under PE_SATURATE_EN).
//  Sub-module pe_mac: combinational signed multiply + sign-extend + add(optional saturate), reused for both
//  WS psum and OS acc paths. systolic_pe holds all registers and mode muxing.
// TESTING
//  1 WS: shift w=3, swap; in_act=5, in_psum=100, in_valid -> next cycle out_psum=115, out_valid=1, out_act=5.
//  2 Signed: WS active_w=-128, in_act=-128, in_psum=0 -> out_psum=16384; in_act=127 -> -16256.
//  3 Double buffer: active_w=2, shift 7 while streaming act=1,psum=0 -> out_psum 2 until swap, 7 after;
//    swap+shift(9) same cycle -> active=7, w_shift_out=9.
//  4 OS: acc_clear, then 4 beats act=1..4, weight=2 -> acc_out 2,6,12,20; acc_clear+valid(act=3,w=3) -> 9.
//  5 Overflow (ACC_W=16): WS in_psum=32767, act=1, w=1 -> -32768 wrap; with PE_SATURATE_EN -> 32767.
//  6 Reset mid-OS tile (acc=20, shadow=7) -> all outputs 0 next cycle, out_valid=0; held in_valid ignored.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, default widths and saturation helper for the systolic PE
package tpu_pkg;

  typedef enum logic {MODE_WS = 1'b0, MODE_OS = 1'b1} pe_mode_e;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 32;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_NEG  = 2'b01,
    SAT_POS  = 2'b10
  } sat_e;

  // Overflow happens only when both operands share a sign that the wrapped sum lacks.
  function automatic sat_e sat_add(input logic a_sign, input logic b_sign, input logic sum_sign);
    if (!a_sign && !b_sign && sum_sign) return SAT_POS;
    if (a_sign && b_sign && !sum_sign) return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - combinational signed multiply-add; PE_SATURATE_EN selects a clamping add
module pe_mac
  import tpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic signed [DATA_W-1:0]   act,
  input  logic signed [WEIGHT_W-1:0] weight,
  input  logic signed [ACC_W-1:0]    addend,
  output logic signed [ACC_W-1:0]    sum
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  if (ACC_W < PROD_W) begin : g_width_check
    $error("pe_mac: ACC_W must be >= DATA_W + WEIGHT_W");
  end

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  raw_sum;

  assign prod     = act * weight;
  assign prod_ext = ACC_W'(prod);
  assign raw_sum  = addend + prod_ext;

`ifdef PE_SATURATE_EN
  sat_e sat_sel;

  assign sat_sel = sat_add(addend[ACC_W-1], prod_ext[ACC_W-1], raw_sum[ACC_W-1]);

  always_comb begin
    sum = raw_sum;
    case (sat_sel)
      SAT_POS: sum = {1'b0, {(ACC_W-1){1'b1}}};
      SAT_NEG: sum = {1'b1, {(ACC_W-1){1'b0}}};
      default: sum = raw_sum;
    endcase
  end
`else
  assign sum = raw_sum;
`endif

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - WS/OS systolic PE with double-buffered weights; PE_SATURATE_EN clamps adds
module systolic_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_act,
  input  logic [ACC_W-1:0]    in_psum,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_act,
  output logic [ACC_W-1:0]    out_psum,
  input  logic                w_shift_en,
  input  logic [WEIGHT_W-1:0] w_shift_in,
  output logic [WEIGHT_W-1:0] w_shift_out,
  input  logic                w_swap,
  input  logic                acc_clear,
  output logic [ACC_W-1:0]    acc_out
);

  pe_mode_e cur_mode;

  logic signed [WEIGHT_W-1:0] active_w;
  logic signed [WEIGHT_W-1:0] shadow_w;
  logic signed [ACC_W-1:0]    acc;

  logic signed [WEIGHT_W-1:0] stream_w;
  logic signed [WEIGHT_W-1:0] mac_w;
  logic signed [ACC_W-1:0]    mac_addend;
  logic signed [ACC_W-1:0]    mac_sum;

  assign cur_mode = pe_mode_e'(mode);
  assign stream_w = in_psum[WEIGHT_W-1:0];

  // One MAC serves both dataflows: WS adds the northern psum, OS adds the local accumulator.
  always_comb begin
    mac_w      = active_w;
    mac_addend = in_psum;
    if (cur_mode == MODE_OS) begin
      mac_w      = stream_w;
      mac_addend = acc_clear ? '0 : acc;
    end
  end

  pe_mac #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .act    (in_act),
    .weight (mac_w),
    .addend (mac_addend),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_act   <= '0;
      out_psum  <= '0;
      active_w  <= '0;
      shadow_w  <= '0;
      acc       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_act  <= in_act;
        out_psum <= (cur_mode == MODE_OS) ? ACC_W'(stream_w) : mac_sum;
      end
      if (cur_mode == MODE_OS && in_valid) begin
        acc <= mac_sum;
      end else if (acc_clear) begin
        acc <= '0;
      end
      // Swap reads the pre-shift shadow value, so swap+shift hands over the old weight.
      if (w_shift_en) shadow_w <= w_shift_in;
      if (w_swap)     active_w <= shadow_w;
    end
  end

  assign w_shift_out = shadow_w;
  assign acc_out     = acc;

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - directed self-checking bench for systolic_pe (32-bit and 16-bit accumulators)
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_act;
  logic [31:0] in_psum;
  logic        w_shift_en;
  logic [7:0]  w_shift_in;
  logic        w_swap;
  logic        acc_clear;

  logic        out_valid, out_valid16;
  logic [7:0]  out_act, out_act16;
  logic [31:0] out_psum, acc_out;
  logic [15:0] out_psum16, acc_out16;
  logic [7:0]  w_shift_out, w_shift_out16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_pe dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_act(in_act),
    .in_psum(in_psum), .out_valid(out_valid), .out_act(out_act), .out_psum(out_psum),
    .w_shift_en(w_shift_en), .w_shift_in(w_shift_in), .w_shift_out(w_shift_out),
    .w_swap(w_swap), .acc_clear(acc_clear), .acc_out(acc_out)
  );

  systolic_pe #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_act(in_act),
    .in_psum(in_psum[15:0]), .out_valid(out_valid16), .out_act(out_act16), .out_psum(out_psum16),
    .w_shift_en(w_shift_en), .w_shift_in(w_shift_in), .w_shift_out(w_shift_out16),
    .w_swap(w_swap), .acc_clear(acc_clear), .acc_out(acc_out16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_act = '0; in_psum = '0;
    w_shift_en = 1'b0; w_shift_in = '0; w_swap = 1'b0; acc_clear = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_act", 32'(out_act), 32'd0);
    chk("rst_out_psum", out_psum, 32'd0);
    chk("rst_w_shift_out", 32'(w_shift_out), 32'd0);
    chk("rst_acc_out", acc_out, 32'd0);
    chk("rst_acc_out16", 32'(acc_out16), 32'd0);
    reset = 1'b0;

    // WS basic: w=3, act=5, psum=100 -> 115
    w_shift_en = 1'b1; w_shift_in = 8'd3; step();
    w_shift_en = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
    chk("ws_shadow3", 32'(w_shift_out), 32'd3);
    in_valid = 1'b1; in_act = 8'd5; in_psum = 32'd100; step();
    chk("ws_psum115", out_psum, 32'd115);
    chk("ws_psum115_16", 32'(out_psum16), 32'd115);
    chk("ws_out_valid", 32'(out_valid), 32'd1);
    chk("ws_out_act", 32'(out_act), 32'd5);

    // Signed extremes with active_w = -128
    in_valid = 1'b0;
    w_shift_en = 1'b1; w_shift_in = 8'h80; step();
    w_shift_en = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
    in_valid = 1'b1; in_act = 8'h80; in_psum = 32'd0; step();
    chk("sgn_neg_neg", out_psum, 32'd16384);
    in_act = 8'd127; step();
    chk("sgn_pos_neg", out_psum, 32'hFFFF_C080);
    chk("sgn_pos_neg16", 32'(out_psum16), 32'h0000_C080);
    in_valid = 1'b0; in_act = 8'd9; step();
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_psum_hold", out_psum, 32'hFFFF_C080);
    chk("bubble_act_hold", 32'(out_act), 32'd127);

    // Double buffer: active 2, shadow loads 7 while streaming
    w_shift_en = 1'b1; w_shift_in = 8'd2; step();
    w_shift_en = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
    in_valid = 1'b1; in_act = 8'd1; in_psum = 32'd0;
    w_shift_en = 1'b1; w_shift_in = 8'd7; step();
    chk("db_psum_old_a", out_psum, 32'd2);
    chk("db_shadow7", 32'(w_shift_out), 32'd7);
    w_shift_en = 1'b0; step();
    chk("db_psum_old_b", out_psum, 32'd2);
    w_swap = 1'b1; w_shift_en = 1'b1; w_shift_in = 8'd9; step();
    chk("db_swap_same_beat", out_psum, 32'd2);
    chk("db_shadow9", 32'(w_shift_out), 32'd9);
    w_swap = 1'b0; w_shift_en = 1'b0; step();
    chk("db_active7", out_psum, 32'd7);
    w_swap = 1'b1; step();
    chk("db_active7_b", out_psum, 32'd7);
    w_swap = 1'b0; step();
    chk("db_active9", out_psum, 32'd9);

    // OS accumulation with streamed weight 2
    in_valid = 1'b0; mode = 1'b1; acc_clear = 1'b1; step();
    acc_clear = 1'b0;
    chk("os_clear", acc_out, 32'd0);
    in_valid = 1'b1; in_psum = 32'd2;
    in_act = 8'd1; step(); chk("os_acc2", acc_out, 32'd2);
    in_act = 8'd2; step(); chk("os_acc6", acc_out, 32'd6);
    in_act = 8'd3; step(); chk("os_acc12", acc_out, 32'd12);
    in_act = 8'd4; step(); chk("os_acc20", acc_out, 32'd20);
    chk("os_acc20_16", 32'(acc_out16), 32'd20);
    chk("os_fwd_w", out_psum, 32'd2);
    acc_clear = 1'b1; in_act = 8'd3; in_psum = 32'd3; step();
    acc_clear = 1'b0;
    chk("os_clear_valid", acc_out, 32'd9);
    in_act = 8'd1; in_psum = 32'h0000_01FE; step();
    chk("os_neg_w_acc", acc_out, 32'd7);
    chk("os_fwd_sext", out_psum, 32'hFFFF_FFFE);
    chk("os_fwd_sext16", 32'(out_psum16), 32'h0000_FFFE);

    // Overflow on the 16-bit instance, WS with w=1
    in_valid = 1'b0; mode = 1'b0;
    w_shift_en = 1'b1; w_shift_in = 8'd1; step();
    w_shift_en = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
    chk("ovf_acc_kept", acc_out, 32'd7);
    in_valid = 1'b1; in_act = 8'd1; in_psum = 32'd32767; step();
    chk("ovf_pos32", out_psum, 32'd32768);
`ifdef PE_SATURATE_EN
    chk("ovf_pos16", 32'(out_psum16), 32'h0000_7FFF);
`else
    chk("ovf_pos16", 32'(out_psum16), 32'h0000_8000);
`endif
    in_act = 8'hFF; in_psum = 32'hFFFF_8000; step();
    chk("ovf_neg32", out_psum, 32'hFFFF_7FFF);
`ifdef PE_SATURATE_EN
    chk("ovf_neg16", 32'(out_psum16), 32'h0000_8000);
`else
    chk("ovf_neg16", 32'(out_psum16), 32'h0000_7FFF);
`endif

    // Reset in the middle of an OS tile
    in_valid = 1'b0; mode = 1'b1; acc_clear = 1'b1; step();
    acc_clear = 1'b0; in_valid = 1'b1; in_psum = 32'd2;
    w_shift_en = 1'b1; w_shift_in = 8'd7;
    in_act = 8'd1; step();
    w_shift_en = 1'b0;
    in_act = 8'd2; step();
    in_act = 8'd3; step();
    in_act = 8'd4; step();
    chk("mid_acc20", acc_out, 32'd20);
    chk("mid_shadow7", 32'(w_shift_out), 32'd7);
    reset = 1'b1; step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_act", 32'(out_act), 32'd0);
    chk("mid_rst_psum", out_psum, 32'd0);
    chk("mid_rst_acc", acc_out, 32'd0);
    chk("mid_rst_shadow", 32'(w_shift_out), 32'd0);
    step();
    chk("mid_rst_hold_valid", 32'(out_valid16), 32'd0);
    chk("mid_rst_hold_acc16", 32'(acc_out16), 32'd0);
    reset = 1'b0; mode = 1'b0; in_act = 8'd5; in_psum = 32'd0; step();
    chk("post_rst_active0", out_psum, 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
